data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_pkg.sv | 13 +
 rtl/data_ram_array.sv | 39 +++
 rtl/data_ram.sv | 89 ++++++++
 tb/tb_data_ram.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared constants and state encoding for the data RAM and its storage array.
package data_ram_pkg;

  localparam int MEM_W           = 32;
  localparam int MEM_ADDR_W      = 32;
  localparam int DRAM_DEPTH_LOG2 = 12;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dram_state_t;

endpackage

// File: rtl/data_ram_array.sv
// Word storage: one write port and one registered read port with write-first forwarding.
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = DRAM_DEPTH_LOG2,
  parameter int DATA_W = MEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_idx,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_idx,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents carry no reset; only explicit writes initialise them.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_idx] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (r_en) begin
      if (w_en && (w_idx == r_idx)) begin
        r_data <= w_data;
      end else begin
        r_data <= mem[r_idx];
      end
    end
  end

endmodule

// File: rtl/data_ram.sv
// Core data RAM: post-reset clear sweep, hold indication and write-port mux.
// Define DRAM_INIT_CLEAR_EN to build the CLEAR sweep; otherwise the RAM is ready at once.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DRAM_DEPTH_LOG2,
  parameter logic [31:0] CLR_VALUE  = 32'h0000_0000
) (
  input  logic                  clk_100MHz,
  input  logic                  arst_n,
  input  logic                  ram_r_ena_i,
  input  logic [MEM_ADDR_W-1:0] ram_r_addr_i,
  input  logic                  ram_w_ena_i,
  input  logic [MEM_ADDR_W-1:0] ram_w_addr_i,
  input  logic [MEM_W-1:0]      ram_w_data_i,
  output logic [MEM_W-1:0]      ram_r_data_o,
  output logic                  ram_hold_o
);

  logic                  clearing;
  logic [DEPTH_LOG2-1:0] sweep_idx;
  logic                  arr_w_en;
  logic [DEPTH_LOG2-1:0] arr_w_idx;
  logic [MEM_W-1:0]      arr_w_data;
  logic                  arr_r_en;
  logic [DEPTH_LOG2-1:0] arr_r_idx;

  // Byte offset and bits above the array span are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_r_addr_i[1:0], ram_r_addr_i[MEM_ADDR_W-1:DEPTH_LOG2+2],
                              ram_w_addr_i[1:0], ram_w_addr_i[MEM_ADDR_W-1:DEPTH_LOG2+2]};

`ifdef DRAM_INIT_CLEAR_EN
  dram_state_t           state;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic                  hold;

  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      hold    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == {DEPTH_LOG2{1'b1}}) begin
            state <= READY;
            hold  <= 1'b0;
          end
        end
        default: begin
          hold <= 1'b0;
        end
      endcase
    end
  end

  assign clearing   = (state == CLEAR);
  assign sweep_idx  = clr_idx;
  assign ram_hold_o = hold;
`else
  assign clearing   = 1'b0;
  assign sweep_idx  = '0;
  assign ram_hold_o = 1'b0;
`endif

  // The sweep owns the write port while clearing; core accesses are dropped.
  assign arr_w_en   = clearing ? 1'b1 : ram_w_ena_i;
  assign arr_w_idx  = clearing ? sweep_idx : ram_w_addr_i[DEPTH_LOG2+1:2];
  assign arr_w_data = clearing ? CLR_VALUE : ram_w_data_i;
  assign arr_r_en   = ram_r_ena_i && !clearing;
  assign arr_r_idx  = ram_r_addr_i[DEPTH_LOG2+1:2];

  data_ram_array #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (MEM_W)
  ) u_array (
    .clk    (clk_100MHz),
    .rst_n  (arst_n),
    .w_en   (arr_w_en),
    .w_idx  (arr_w_idx),
    .w_data (arr_w_data),
    .r_en   (arr_r_en),
    .r_idx  (arr_r_idx),
    .r_data (ram_r_data_o)
  );

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram; covers both builds selected by DRAM_INIT_CLEAR_EN.
module tb_data_ram;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic        ram_r_ena_i;
  logic [31:0] ram_r_addr_i;
  logic        ram_w_ena_i;
  logic [31:0] ram_w_addr_i;
  logic [31:0] ram_w_data_i;
  logic [31:0] ram_r_data_o;
  logic        ram_hold_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [4096];

  always #5 clk_100MHz = ~clk_100MHz;

  data_ram dut (
    .clk_100MHz   (clk_100MHz),
    .arst_n       (arst_n),
    .ram_r_ena_i  (ram_r_ena_i),
    .ram_r_addr_i (ram_r_addr_i),
    .ram_w_ena_i  (ram_w_ena_i),
    .ram_w_addr_i (ram_w_addr_i),
    .ram_w_data_i (ram_w_data_i),
    .ram_r_data_o (ram_r_data_o),
    .ram_hold_o   (ram_hold_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample at the next negedge. "ready" says the
  // access reaches the array, so only then is the model touched and a result queued.
  task automatic step(input string tag, input logic re, input logic [31:0] ra,
                      input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic ready);
    int ri, wi;
    logic [31:0] exp;
    ri = int'(ra[13:2]);
    wi = int'(wa[13:2]);
    ram_r_ena_i  = re;
    ram_r_addr_i = ra;
    ram_w_ena_i  = we;
    ram_w_addr_i = wa;
    ram_w_data_i = wd;
    if (re && ready) exp_q.push_back((we && wi == ri) ? wd : model[ri]);
    if (we && ready) model[wi] = wd;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    ram_r_ena_i = 1'b0;
    ram_w_ena_i = 1'b0;
    if (re && ready) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check(tag, ram_r_data_o, exp);
      end
    end
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, ready);
  endtask

  // Counts cycles with hold high; writes/reads injected mid-sweep must be ignored.
  task automatic sweep(output int cnt, input int stop_at);
    cnt = 0;
    while (ram_hold_o && cnt < 5000 && cnt != stop_at) begin
      if (cnt == 10) begin
        step("clr_wr", 1'b0, 32'h0, 1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 1'b0);
      end else if (cnt == 20) begin
        step("clr_rd", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b0);
        check("clr_rd_zero", ram_r_data_o, 32'h0);
      end else begin
        step("sweep", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      cnt++;
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] last;
    logic [31:0] addrs [8];
    addrs = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h4020, 32'h3FFC, 32'h0FFC, 32'h7FF0};
    foreach (model[i]) model[i] = 32'h0;
    arst_n = 1'b0;
    ram_r_ena_i = 1'b0; ram_r_addr_i = '0;
    ram_w_ena_i = 1'b0; ram_w_addr_i = '0; ram_w_data_i = '0;
    @(negedge clk_100MHz);
    idle(2, 1'b0);
    check("rst_rdata", ram_r_data_o, 32'h0);

`ifdef DRAM_INIT_CLEAR_EN
    check("rst_hold", {31'd0, ram_hold_o}, 32'd1);
    arst_n = 1'b1;
    sweep(cnt, -1);
    check("hold_len", cnt, 32'd4096);
    check("hold_low", {31'd0, ram_hold_o}, 32'd0);
    step("rd_0ffc", 1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 32'h0, 1'b1);
    step("rd_3ffc", 1'b1, 32'h0000_3FFC, 1'b0, 32'h0, 32'h0, 1'b1);
`else
    check("rst_hold", {31'd0, ram_hold_o}, 32'd0);
    arst_n = 1'b1;
    idle(1, 1'b1);
    check("hold_ready", {31'd0, ram_hold_o}, 32'd0);
    step("wr_cafe", 1'b0, 32'h0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1);
    step("rd_cafe", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b1);
`endif

    step("wr_beef", 1'b0, 32'h0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step("rd_beef", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b1);
    step("rw_same", 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1);
    step("rd_alias", 1'b1, 32'h0000_4020, 1'b0, 32'h0, 32'h0, 1'b1);
    step("rd_byte", 1'b1, 32'h0000_0023, 1'b0, 32'h0, 32'h0, 1'b1);
    step("rw_diff", 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 1'b1);
    step("rd_30", 1'b1, 32'h0000_0030, 1'b0, 32'h0, 32'h0, 1'b1);
    step("b2b_0", 1'b1, 32'h0000_0020, 1'b0, 32'h0, 32'h0, 1'b1);
    step("b2b_1", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b1);
    step("b2b_2", 1'b1, 32'h0000_0030, 1'b0, 32'h0, 32'h0, 1'b1);
    last = 32'h0BAD_F00D;
    step("wr_only", 1'b0, 32'h0, 1'b1, 32'h0000_0030, 32'h5555_AAAA, 1'b1);
    check("rd_hold", ram_r_data_o, last);

    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)],
           1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom, 1'b1);
    end

    step("set_10", 1'b0, 32'h0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step("rd_pre", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b1);
    arst_n = 1'b0;
    step("rst_flush", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_flush", ram_r_data_o, 32'h0);
    arst_n = 1'b1;

`ifdef DRAM_INIT_CLEAR_EN
    sweep(cnt, 2000);
    check("mid_sweep", cnt, 32'd2000);
    arst_n = 1'b0;
    idle(1, 1'b0);
    arst_n = 1'b1;
    sweep(cnt, -1);
    check("hold_len2", cnt, 32'd4096);
    foreach (model[i]) model[i] = 32'h0;
    step("rd_10_clr", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b1);
`else
    idle(1, 1'b1);
    check("hold_ready2", {31'd0, ram_hold_o}, 32'd0);
    step("rd_10_keep", 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 1'b1);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
